adxl362_axis_reader: RTL and testbench



---
 rtl/adxl362_pkg.sv | 30 +++
 rtl/adxl362_axis_reader_spi_byte_shifter.sv | 76 +++++++
 rtl/adxl362_axis_reader.sv | 205 ++++++++++++++++++++
 tb/tb_adxl362_axis_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_pkg.sv
// ADXL362 reader shared definitions: SPI opcodes, register addresses,
// channel indices and the sequencing state enum.
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;

  localparam int CH_X     = 0;
  localparam int CH_Y     = 1;
  localparam int CH_Z     = 2;
  localparam int CH_TEMP  = 3;
  localparam int MAX_AXES = 4;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_W_CMD,
    ST_W_ADDR,
    ST_W_DATA,
    ST_IFG_INIT,
    ST_IDLE,
    ST_R_CMD,
    ST_R_ADDR,
    ST_R_DATA,
    ST_R_END,
    ST_IFG
  } state_e;

endpackage

// File: rtl/adxl362_axis_reader_spi_byte_shifter.sv
// Mode-0 SPI byte engine: owns the SCLK divider and gating.
// Ports: clk_i/rst_i, load_i+tx_byte_i start a byte, done_o marks the
// final SCLK fall (load again in that cycle for back-to-back bytes),
// rx_byte_o holds the byte sampled on the SCLK rising edges.
module spi_byte_shifter
  import adxl362_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       done_o,
  output logic [7:0] rx_byte_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic          active_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic          sclk_q;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;
  logic          half_end;

  assign half_end = active_q && (div_q == DIV_LAST);
  // Asserted on the edge where the eighth high phase ends.
  assign done_o   = half_end && sclk_q && (bit_q == 3'd7);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else if (load_i) begin
      // MSB is on mosi from here, a full low half-period before the rise.
      active_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      tx_q     <= tx_byte_i;
    end else if (active_q) begin
      if (half_end) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd7) begin
            active_q <= 1'b0;
          end else begin
            bit_q <= bit_q + 3'd1;
            tx_q  <= {tx_q[6:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign sclk_o    = sclk_q & active_q;
  assign mosi_o    = tx_q[7] & active_q;
  assign rx_byte_o = rx_q;

endmodule

// File: rtl/adxl362_axis_reader.sv
// ADXL362 reader: one POWER_CTL write after power-up, then burst reads
// of NUM_AXES 16-bit channels (X,Y,Z,TEMP) on start or continuously.
// Ports: iclk/rst, SPI pins (sclk,mosi,miso,cs), continuous/start
// requests, sample/sample_valid result, busy and init_done status.
module adxl362_axis_reader
  import adxl362_pkg::*;
#(
  parameter int          NUM_AXES    = 3,
  parameter int          DIV         = 2,
  parameter int          PWRUP_TICKS = 24000,
  parameter int          IFG_TICKS   = 40000,
  parameter logic [7:0]  POWER_MODE  = 8'h02
) (
  input  logic                    iclk,
  input  logic                    rst,
  input  logic                    miso,
  output logic                    sclk,
  output logic                    mosi,
  output logic                    cs,
  input  logic                    continuous,
  input  logic                    start,
  output logic [16*NUM_AXES-1:0]  sample,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    init_done
);

  localparam int NB   = 2 * NUM_AXES;
  localparam int SW   = 16 * NUM_AXES;
  localparam int TMAX = (PWRUP_TICKS > IFG_TICKS) ? PWRUP_TICKS : IFG_TICKS;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [CW-1:0] PWR_LAST  = CW'(PWRUP_TICKS - 1);
  localparam logic [CW-1:0] IFG_LAST  = CW'(IFG_TICKS - 1);
  localparam logic [2:0]    LAST_BYTE = 3'(NB - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    byte_q;
  logic [SW-1:0] stage_q;
  logic [SW-1:0] sample_q;
  logic          cs_q;
  logic          valid_q;
  logic          busy_q;
  logic          init_q;

  logic          sh_load;
  logic [7:0]    sh_tx;
  logic          sh_done;
  logic [7:0]    sh_rx;
  logic          sh_sclk;
  logic          sh_mosi;
  logic          pwr_last;
  logic          ifg_last;
  logic          go;
  logic          last_byte;

  assign pwr_last  = (cnt_q == PWR_LAST);
  assign ifg_last  = (cnt_q == IFG_LAST);
  assign go        = continuous | start;
  assign last_byte = (byte_q == LAST_BYTE);

  // Byte issue is decoded combinationally so the next byte is loaded on
  // the same edge the previous one finishes: no SCLK gap inside a frame.
  always_comb begin
    sh_load = 1'b0;
    sh_tx   = 8'h00;
    unique case (state_q)
      ST_PWRUP: if (pwr_last) begin
        sh_load = 1'b1;
        sh_tx   = CMD_WRITE;
      end
      ST_W_CMD: if (sh_done) begin
        sh_load = 1'b1;
        sh_tx   = REG_POWER_CTL;
      end
      ST_W_ADDR: if (sh_done) begin
        sh_load = 1'b1;
        sh_tx   = POWER_MODE;
      end
      ST_IDLE: if (go) begin
        sh_load = 1'b1;
        sh_tx   = CMD_READ;
      end
      ST_R_CMD: if (sh_done) begin
        sh_load = 1'b1;
        sh_tx   = REG_XDATA_L;
      end
      ST_R_ADDR: if (sh_done) begin
        sh_load = 1'b1;
      end
      ST_R_DATA: if (sh_done && !last_byte) begin
        sh_load = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q  <= ST_PWRUP;
      cnt_q    <= '0;
      byte_q   <= '0;
      stage_q  <= '0;
      sample_q <= '0;
      cs_q     <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b1;
      init_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_PWRUP: begin
          if (pwr_last) begin
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            state_q <= ST_W_CMD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_W_CMD: if (sh_done) state_q <= ST_W_ADDR;
        ST_W_ADDR: if (sh_done) state_q <= ST_W_DATA;
        ST_W_DATA: begin
          if (sh_done) begin
            cs_q    <= 1'b1;
            state_q <= ST_IFG_INIT;
          end
        end
        ST_IFG_INIT: begin
          if (ifg_last) begin
            cnt_q   <= '0;
            init_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (go) begin
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_R_CMD;
          end
        end
        ST_R_CMD: if (sh_done) state_q <= ST_R_ADDR;
        ST_R_ADDR: begin
          if (sh_done) begin
            byte_q  <= '0;
            state_q <= ST_R_DATA;
          end
        end
        ST_R_DATA: begin
          if (sh_done) begin
            // Even bytes land in the low half of a channel, odd in the high.
            for (int b = 0; b < NB; b++) begin
              if (byte_q == 3'(b)) stage_q[8*b +: 8] <= sh_rx;
            end
            if (last_byte) state_q <= ST_R_END;
            else           byte_q  <= byte_q + 3'd1;
          end
        end
        ST_R_END: begin
          cs_q     <= 1'b1;
          sample_q <= stage_q;
          valid_q  <= 1'b1;
          state_q  <= ST_IFG;
        end
        ST_IFG: begin
          if (ifg_last) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  spi_byte_shifter #(
    .DIV (DIV)
  ) u_shift (
    .clk_i     (iclk),
    .rst_i     (rst),
    .load_i    (sh_load),
    .tx_byte_i (sh_tx),
    .miso_i    (miso),
    .sclk_o    (sh_sclk),
    .mosi_o    (sh_mosi),
    .done_o    (sh_done),
    .rx_byte_o (sh_rx)
  );

  assign sclk         = sh_sclk & ~cs_q;
  assign mosi         = sh_mosi & ~cs_q;
  assign cs           = cs_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign init_done    = init_q;

endmodule

// File: tb/tb_adxl362_axis_reader.sv
// Bench for adxl362_axis_reader: three instances (3, 4 and 1 axes)
// driven by a behavioural ADXL362 model with a byte/sample scoreboard.
module tb_adxl362_axis_reader;

  localparam int DIV = 2;
  localparam int PT  = 20;
  localparam int IT  = 30;
  localparam int BYT = 16 * DIV;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic [2:0] rst_r   = 3'b111;
  logic [2:0] start_r = 3'b000;
  logic [2:0] cont_r  = 3'b000;
  logic [2:0] miso_r  = 3'b000;
  logic [2:0] cs_w, sclk_w, mosi_w, sv_w, busy_w, init_w;
  logic [47:0] s0;
  logic [63:0] s1;
  logic [15:0] s2;
  logic [63:0] smp [3];

  always_comb begin
    smp[0] = {16'h0, s0};
    smp[1] = s1;
    smp[2] = {48'h0, s2};
  end

  adxl362_axis_reader #(.NUM_AXES(3), .DIV(DIV), .PWRUP_TICKS(PT),
    .IFG_TICKS(IT), .POWER_MODE(8'h02)) u0 (
    .iclk(iclk), .rst(rst_r[0]), .miso(miso_r[0]), .sclk(sclk_w[0]),
    .mosi(mosi_w[0]), .cs(cs_w[0]), .continuous(cont_r[0]),
    .start(start_r[0]), .sample(s0), .sample_valid(sv_w[0]),
    .busy(busy_w[0]), .init_done(init_w[0]));

  adxl362_axis_reader #(.NUM_AXES(4), .DIV(DIV), .PWRUP_TICKS(PT),
    .IFG_TICKS(IT), .POWER_MODE(8'h02)) u1 (
    .iclk(iclk), .rst(rst_r[1]), .miso(miso_r[1]), .sclk(sclk_w[1]),
    .mosi(mosi_w[1]), .cs(cs_w[1]), .continuous(cont_r[1]),
    .start(start_r[1]), .sample(s1), .sample_valid(sv_w[1]),
    .busy(busy_w[1]), .init_done(init_w[1]));

  adxl362_axis_reader #(.NUM_AXES(1), .DIV(DIV), .PWRUP_TICKS(PT),
    .IFG_TICKS(IT), .POWER_MODE(8'h02)) u2 (
    .iclk(iclk), .rst(rst_r[2]), .miso(miso_r[2]), .sclk(sclk_w[2]),
    .mosi(mosi_w[2]), .cs(cs_w[2]), .continuous(cont_r[2]),
    .start(start_r[2]), .sample(s2), .sample_valid(sv_w[2]),
    .busy(busy_w[2]), .init_done(init_w[2]));

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  eb [3][$];
  logic [63:0] es [3][$];

  logic [63:0] img [3];
  logic [2:0]  pcs = 3'b111;
  logic [2:0]  psclk = 3'b000;
  int          bitn [3];
  int          byten [3];
  int          mcount [3];
  logic [7:0]  shr [3];
  logic [7:0]  first [3];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual %0h required nothing", nm, act);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      img[i] = '0; bitn[i] = 0; byten[i] = 0;
      mcount[i] = 0; shr[i] = '0; first[i] = '0;
    end
  end

  // Device model plus monitor; runs on the falling iclk edge.
  always @(negedge iclk) begin : model
    logic [63:0] t;
    for (int i = 0; i < 3; i++) begin
      if (sv_w[i]) begin
        if (es[i].size() == 0) flag($sformatf("extra_strobe%0d", i), smp[i]);
        else chk($sformatf("sample%0d", i), smp[i], es[i].pop_front());
      end
      if (cs_w[i]) begin
        if (!pcs[i] && i == 1 && first[i] == 8'h0B)
          img[1][15:0] = img[1][15:0] + 16'd1;
        bitn[i] = 0;
        byten[i] = 0;
        miso_r[i] = 1'b0;
      end else begin
        if (sclk_w[i] && !psclk[i]) begin
          shr[i] = {shr[i][6:0], mosi_w[i]};
          bitn[i]++;
          if (bitn[i] == 8) begin
            if (byten[i] == 0) first[i] = shr[i];
            if (eb[i].size() == 0) flag($sformatf("extra_mosi%0d", i), shr[i]);
            else chk($sformatf("mosi%0d", i), shr[i], eb[i].pop_front());
            mcount[i]++;
            byten[i]++;
            bitn[i] = 0;
          end
        end
        if (!sclk_w[i] && psclk[i]) begin
          if (byten[i] >= 2) begin
            t = img[i] >> (8 * (byten[i] - 2));
            miso_r[i] = t[7 - bitn[i]];
          end else begin
            miso_r[i] = 1'b0;
          end
        end
      end
      pcs[i] = cs_w[i];
      psclk[i] = sclk_w[i];
    end
  end

  // sel: 0 cs, 1 init_done, 2 sample_valid, 3 busy
  task automatic wait_sig(input int sel, input int i, input logic v,
                          input int bound, output int cyc);
    logic s;
    cyc = 0;
    do begin
      @(posedge iclk); #1;
      cyc++;
      case (sel)
        0: s = cs_w[i];
        1: s = init_w[i];
        2: s = sv_w[i];
        default: s = busy_w[i];
      endcase
    end while (s !== v && cyc < bound);
    if (s !== v) flag($sformatf("timeout_sel%0d_inst%0d", sel, i), cyc);
  endtask

  task automatic push_frame(input int i, input int nax, input logic [63:0] v);
    eb[i].push_back(8'h0B);
    eb[i].push_back(8'h0E);
    for (int k = 0; k < 2 * nax; k++) eb[i].push_back(8'h00);
    es[i].push_back(v);
  endtask

  task automatic do_init(input int i);
    int c;
    eb[i].push_back(8'h0A);
    eb[i].push_back(8'h2D);
    eb[i].push_back(8'h02);
    @(posedge iclk); #1;
    rst_r[i] = 1'b0;
    wait_sig(0, i, 1'b0, 200, c);
    chk("pwrup_to_cs", c, PT);
    wait_sig(0, i, 1'b1, 300, c);
    chk("init_cs_low", c, 3 * BYT);
    wait_sig(1, i, 1'b1, 200, c);
    chk("ifg_init", c, IT);
    chk("busy_after_init", busy_w[i], 1'b0);
  endtask

  task automatic do_frame(input int i, input int nax, input logic [63:0] v);
    int c;
    push_frame(i, nax, v);
    start_r[i] = 1'b1;
    @(posedge iclk); #1;
    start_r[i] = 1'b0;
    chk("start_cs", cs_w[i], 1'b0);
    chk("start_busy", busy_w[i], 1'b1);
    wait_sig(0, i, 1'b1, 1000, c);
    chk("cs_low_len", c, (2 + 2 * nax) * BYT + 1);
    chk("strobe_with_cs", sv_w[i], 1'b1);
    @(posedge iclk); #1;
    chk("strobe_width", sv_w[i], 1'b0);
    // Counted from one cycle after the strobe.
    wait_sig(3, i, 1'b0, 100, c);
    chk("ifg_len", c, IT - 1);
    chk("sample_hold", smp[i], v);
  endtask

  initial begin
    int c;
    int base;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_cs", cs_w[0], 1'b1);
    chk("rst_sclk", sclk_w[0], 1'b0);
    chk("rst_mosi", mosi_w[0], 1'b0);
    chk("rst_sample", smp[0], 64'h0);
    chk("rst_valid", sv_w[0], 1'b0);
    chk("rst_busy", busy_w[0], 1'b1);
    chk("rst_init", init_w[0], 1'b0);

    img[0] = 64'h0000_07FF_FF80_0123;
    do_init(0);
    do_frame(0, 3, 64'h0000_07FF_FF80_0123);

    // Continuous cleared mid-frame plus a start while busy.
    img[0] = 64'h0000_8000_0001_A5C3;
    push_frame(0, 3, 64'h0000_8000_0001_A5C3);
    cont_r[0] = 1'b1;
    @(posedge iclk); #1;
    chk("cont_launch", cs_w[0], 1'b0);
    repeat (100) @(posedge iclk);
    #1;
    cont_r[0] = 1'b0;
    start_r[0] = 1'b1;
    chk("busy_mid_frame", busy_w[0], 1'b1);
    @(posedge iclk); #1;
    start_r[0] = 1'b0;
    wait_sig(2, 0, 1'b1, 400, c);
    repeat (IT + 10) @(posedge iclk);
    #1;
    chk("idle_after_toggle", busy_w[0], 1'b0);
    chk("cs_after_toggle", cs_w[0], 1'b1);

    // Reset while data byte 3 is shifting.
    img[0] = 64'h0000_1111_2222_3333;
    eb[0].push_back(8'h0B);
    eb[0].push_back(8'h0E);
    for (int k = 0; k < 3; k++) eb[0].push_back(8'h00);
    base = mcount[0];
    start_r[0] = 1'b1;
    @(posedge iclk); #1;
    start_r[0] = 1'b0;
    for (int n = 0; n < 400 && mcount[0] < base + 5; n++) @(posedge iclk);
    chk("reach_byte3", mcount[0] - base, 5);
    repeat (10) @(posedge iclk);
    #1;
    rst_r[0] = 1'b1;
    @(posedge iclk); #1;
    chk("abort_cs", cs_w[0], 1'b1);
    chk("abort_sclk", sclk_w[0], 1'b0);
    chk("abort_sample", smp[0], 64'h0);
    chk("abort_init", init_w[0], 1'b0);
    chk("abort_busy", busy_w[0], 1'b1);
    do_init(0);
    do_frame(0, 3, 64'h0000_1111_2222_3333);

    // Four channels, continuous, X increments every frame.
    img[1] = 64'h0210_FEDC_1234_1000;
    do_init(1);
    for (int k = 0; k < 3; k++)
      push_frame(1, 4, 64'h0210_FEDC_1234_1000 + 64'(k));
    cont_r[1] = 1'b1;
    wait_sig(2, 1, 1'b1, 1000, c);
    for (int k = 1; k < 3; k++) begin
      wait_sig(2, 1, 1'b1, 1000, c);
      chk("cont_period", c, 10 * BYT + 1 + IT + 1);
    end
    cont_r[1] = 1'b0;
    repeat (IT + 50) @(posedge iclk);
    #1;
    chk("cont_stop_busy", busy_w[1], 1'b0);
    chk("cont_stop_cs", cs_w[1], 1'b1);

    // Single channel.
    img[2] = 64'h0000_0000_0000_BEEF;
    do_init(2);
    do_frame(2, 1, 64'h0000_0000_0000_BEEF);

    repeat (20) @(posedge iclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mosi_left%0d", i), eb[i].size(), 0);
      chk($sformatf("strobe_left%0d", i), es[i].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
